// File: rtl/sdram_beat_unpack.sv
// Beat FIFO plus element unpacker between the SDRAM burst reader and the NPU buffers.
// Optional statistics counters are built only when SDRAM_UNPACK_STATS_EN is defined.
module sdram_beat_unpack #(
  parameter int SDRAM_W = 128,
  parameter int ELEM_W  = 8,
  parameter int DEPTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [10:0]                          in_idx,
  input  logic [SDRAM_W-1:0]                   in_data,
  input  logic                                 rsv_req,
  input  logic [10:0]                          rsv_cnt,
  output logic                                 rsv_grant,
  output logic                                 rsv_err,
  output logic                                 elem_valid,
  input  logic                                 elem_ready,
  output logic [ELEM_W-1:0]                    elem_data,
  output logic [$clog2(SDRAM_W/ELEM_W)-1:0]    elem_lane,
  output logic [$clog2(DEPTH):0]               level,
  output logic                                 overflow,
  output logic                                 idx_err,
  output logic [31:0]                          stat_beats,
  output logic [31:0]                          stat_elems
);

  localparam int LANES  = SDRAM_W / ELEM_W;
  localparam int LANE_W = $clog2(LANES);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
  localparam logic [11:0]       DEPTH_12  = 12'(DEPTH);

  logic [SDRAM_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]  reserved_q, reserved_d;
  logic [10:0]       exp_idx_q, exp_idx_d;
  logic              overflow_q, overflow_d;
  logic              idx_err_q, idx_err_d;
  logic              rsv_err_q, rsv_err_d;

  logic              wr_en;
  logic              elem_hs;
  logic              pop;
  logic              rsv_legal;
  logic [11:0]       used;
  logic [11:0]       free;
  logic [CNT_W-1:0]  rsv_sum;

  // Write, handshake and pop qualifiers.
  assign wr_en      = in_valid && (count_q != FULL);
  assign elem_valid = (count_q != '0);
  assign elem_hs    = elem_valid && elem_ready;
  assign pop        = elem_hs && (lane_q == LAST_LANE);

  // Free space counts both stored beats and beats promised to in-flight bursts.
  assign used      = 12'(count_q) + 12'(reserved_q);
  assign free      = (used >= DEPTH_12) ? 12'd0 : (DEPTH_12 - used);
  assign rsv_legal = (rsv_cnt != 11'd0) && ({1'b0, rsv_cnt} <= DEPTH_12);
  assign rsv_grant = !rst && rsv_req && rsv_legal && ({1'b0, rsv_cnt} <= free);

  // NOTE: every variable gets a default at the top of always_comb, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lane_d     = lane_q;
    exp_idx_d  = exp_idx_q;
    overflow_d = overflow_q;
    idx_err_d  = idx_err_q;
    rsv_err_d  = rsv_req && !rsv_legal;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (wr_en && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    if (elem_hs) begin
      lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
    end

    // Sequence check covers dropped beats too; index 0 always restarts cleanly.
    if (in_valid) begin
      exp_idx_d = in_idx + 11'd1;
      if ((in_idx != 11'd0) && (in_idx != exp_idx_q)) begin
        idx_err_d = 1'b1;
      end
      if (count_q == FULL) begin
        overflow_d = 1'b1;
      end
    end
  end

  // A grant never exceeds free space, so the sum always fits in CNT_W bits.
  assign rsv_sum    = reserved_q + (rsv_grant ? CNT_W'(rsv_cnt) : CNT_W'(0));
  assign reserved_d = (wr_en && (rsv_sum != '0)) ? rsv_sum - CNT_W'(1) : rsv_sum;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lane_q     <= '0;
      reserved_q <= '0;
      exp_idx_q  <= '0;
      overflow_q <= 1'b0;
      idx_err_q  <= 1'b0;
      rsv_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lane_q     <= lane_d;
      reserved_q <= reserved_d;
      exp_idx_q  <= exp_idx_d;
      overflow_q <= overflow_d;
      idx_err_q  <= idx_err_d;
      rsv_err_q  <= rsv_err_d;
    end
  end

  // NOTE: the storage array is reset so elem_data never reads X, at the cost of reset fan-out into every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign elem_data = mem_q[rd_ptr_q][lane_q*ELEM_W +: ELEM_W];
  assign elem_lane = lane_q;
  assign level     = count_q;
  assign overflow  = overflow_q;
  assign idx_err   = idx_err_q;
  assign rsv_err   = rsv_err_q;

`ifdef SDRAM_UNPACK_STATS_EN
  logic [31:0] stat_beats_q;
  logic [31:0] stat_elems_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats_q <= '0;
      stat_elems_q <= '0;
    end else begin
      if (wr_en) begin
        stat_beats_q <= stat_beats_q + 32'd1;
      end
      if (elem_hs) begin
        stat_elems_q <= stat_elems_q + 32'd1;
      end
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_elems = stat_elems_q;
`else
  assign stat_beats = 32'd0;
  assign stat_elems = 32'd0;
`endif

endmodule

// File: tb/tb_sdram_beat_unpack.sv
// Scoreboard bench for sdram_beat_unpack: stimulus pushes expected elements, a negedge monitor pops and compares.
module tb_sdram_beat_unpack;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [10:0]  in_idx;
  logic [127:0] in_data;
  logic         rsv_req;
  logic [10:0]  rsv_cnt;
  logic         rsv_grant;
  logic         rsv_err;
  logic         elem_valid;
  logic         elem_ready;
  logic [7:0]   elem_data;
  logic [3:0]   elem_lane;
  logic [4:0]   level;
  logic         overflow;
  logic         idx_err;
  logic [31:0]  stat_beats;
  logic [31:0]  stat_elems;

  typedef struct packed {
    logic [3:0] lane;
    logic [7:0] data;
  } elem_t;

  elem_t sb_q[$];
  int    checks = 0;
  int    errors = 0;

  sdram_beat_unpack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_idx     (in_idx),
    .in_data    (in_data),
    .rsv_req    (rsv_req),
    .rsv_cnt    (rsv_cnt),
    .rsv_grant  (rsv_grant),
    .rsv_err    (rsv_err),
    .elem_valid (elem_valid),
    .elem_ready (elem_ready),
    .elem_data  (elem_data),
    .elem_lane  (elem_lane),
    .level      (level),
    .overflow   (overflow),
    .idx_err    (idx_err),
    .stat_beats (stat_beats),
    .stat_elems (stat_elems)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every handshake observed mid-cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && elem_valid && elem_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL elem_unexpected: got lane=%0d data=%h with nothing expected", elem_lane, elem_data);
      end else begin
        elem_t e;
        e = sb_q.pop_front();
        if (elem_lane !== e.lane || elem_data !== e.data) begin
          errors++;
          $display("FAIL elem: got lane=%0d data=%h expected lane=%0d data=%h",
                   elem_lane, elem_data, e.lane, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k carries byte (k*16 + lane) in each lane.
  function automatic logic [127:0] bd(input int k);
    logic [127:0] d;
    for (int l = 0; l < 16; l++) d[l*8 +: 8] = 8'(k*16 + l);
    return d;
  endfunction

  task automatic push_beat(input logic [127:0] d);
    elem_t e;
    for (int l = 0; l < 16; l++) begin
      e.lane = 4'(l);
      e.data = d[l*8 +: 8];
      sb_q.push_back(e);
    end
  endtask

  task automatic send_beat(input logic [127:0] d, input int idx, input bit accept);
    in_valid = 1'b1;
    in_data  = d;
    in_idx   = 11'(idx);
    if (accept) push_beat(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_data = '0;
    rsv_req = 1'b0; rsv_cnt = '0; elem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic drain(input string name);
    int n;
    elem_ready = 1'b1;
    for (n = 0; n < 2000; n++) begin
      if (sb_q.size() == 0 && !elem_valid) break;
      tick();
    end
    check({name, "_drain_left"}, sb_q.size(), 0);
    check({name, "_drain_level"}, level, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;
    #1;
    // Reset state
    do_reset();
    check("rst_elem_valid", elem_valid, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_idx_err", idx_err, 0);
    check("rst_rsv_err", rsv_err, 0);
    check("rst_rsv_grant", rsv_grant, 0);
    check("rst_elem_data", elem_data, 0);
    check("rst_stat_beats", stat_beats, 0);

    // Single beat unpacks LSB-first over 16 consecutive cycles
    elem_ready = 1'b1;
    send_beat(128'h0F0E0D0C0B0A09080706050403020100, 0, 1'b1);
    check("single_valid_n1", elem_valid, 1);
    check("single_level_n1", level, 1);
    check("single_first", elem_data, 8'h00);
    repeat (16) tick();
    check("single_level_end", level, 0);
    check("single_sb_empty", sb_q.size(), 0);

    // Reservation: full reservation, second request waits for the first pop
    do_reset();
    rsv_req = 1'b1; rsv_cnt = 11'd16;
    #1 check("rsv16_grant", rsv_grant, 1);
    tick();
    rsv_cnt = 11'd1;
    #1 check("rsv1_wait", rsv_grant, 0);
    elem_ready = 1'b1;
    early = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_data = bd(k); in_idx = 11'(k);
      push_beat(bd(k));
      #1 if (rsv_grant) early = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1 check("rsv1_no_early_grant", early, 0);
    check("rsv1_before_pop", rsv_grant, 0);
    check("rsv1_no_err", rsv_err, 0);
    tick();
    check("rsv1_after_pop", rsv_grant, 1);
    tick();
    rsv_req = 1'b0;
    drain("rsv");
    check("rsv_overflow", overflow, 0);
    check("rsv_idx_err", idx_err, 0);

    // Fill to full, 17th beat dropped
    do_reset();
    for (int k = 0; k < 16; k++) send_beat(bd(k), k, 1'b1);
    send_beat({16{8'hEE}}, 16, 1'b0);
    check("fill_overflow", overflow, 1);
    check("fill_level", level, 16);
    check("fill_head_data", elem_data, 8'h00);
    check("fill_head_lane", elem_lane, 0);
    check("fill_idx_err", idx_err, 0);
    drain("fill");

    // Write coinciding with the final-lane pop at level 3
    do_reset();
    for (int k = 0; k < 3; k++) send_beat(bd(k), k, 1'b1);
    elem_ready = 1'b1;
    repeat (15) tick();
    check("simul_lane_before", elem_lane, 15);
    check("simul_level_before", level, 3);
    send_beat(bd(3), 3, 1'b1);
    elem_ready = 1'b0;
    check("simul_level_after", level, 3);
    check("simul_lane_after", elem_lane, 0);
    check("simul_next_data", elem_data, 8'h10);
    drain("simul");

    // Index sequence 0,1,3
    do_reset();
    elem_ready = 1'b1;
    send_beat(bd(0), 0, 1'b1);
    send_beat(bd(1), 1, 1'b1);
    check("idx_ok", idx_err, 0);
    send_beat(bd(2), 3, 1'b1);
    check("idx_gap", idx_err, 1);
    send_beat(bd(3), 0, 1'b1);
    check("idx_sticky", idx_err, 1);
    drain("idx");

    // Illegal reservation sizes pulse rsv_err
    rsv_req = 1'b1; rsv_cnt = 11'd0;
    #1 check("rsv0_grant", rsv_grant, 0);
    tick();
    rsv_req = 1'b0;
    check("rsv0_err_pulse", rsv_err, 1);
    tick();
    check("rsv0_err_clear", rsv_err, 0);
    rsv_req = 1'b1; rsv_cnt = 11'd17;
    #1 check("rsv17_grant", rsv_grant, 0);
    tick();
    rsv_req = 1'b0;
    check("rsv17_err_pulse", rsv_err, 1);

    // Reset in the middle of unpacking a beat (idx_err still set from above)
    elem_ready = 1'b1;
    send_beat(bd(5), 1, 1'b1);
    repeat (5) tick();
    check("mid_lane", elem_lane, 5);
    elem_ready = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_data = bd(6); in_idx = 11'd9;
    rsv_req = 1'b1; rsv_cnt = 11'd1;
    #1 check("mid_rst_grant", rsv_grant, 0);
    tick();
    rst = 1'b0; in_valid = 1'b0; rsv_req = 1'b0;
    sb_q.delete();
    check("mid_elem_valid", elem_valid, 0);
    check("mid_level", level, 0);
    check("mid_lane_clr", elem_lane, 0);
    check("mid_idx_err", idx_err, 0);
    check("mid_elem_data", elem_data, 0);

    // Statistics after four fully drained beats
    do_reset();
    for (int k = 0; k < 4; k++) send_beat(bd(k), k, 1'b1);
    drain("stats");
`ifdef SDRAM_UNPACK_STATS_EN
    check("stat_beats", stat_beats, 4);
    check("stat_elems", stat_elems, 64);
`else
    check("stat_beats", stat_beats, 0);
    check("stat_elems", stat_elems, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_beat_unpack.md
# sdram_beat_unpack

Downstream consumer of the SDRAM burst reader. It accepts the reader's 128-bit beats, which arrive with no backpressure, into a beat FIFO. It then unpacks each beat into ELEM_W-wide elements on a valid/ready stream toward the NPU buffers. A space-reservation handshake lets the burst-issuing controller start a burst only when the FIFO can absorb every beat of that burst.

## Interface
- SDRAM_W, 128: beat width; must be a multiple of ELEM_W.
- ELEM_W, 8: output element width.
- DEPTH, 16: FIFO depth in beats; power of 2, at least 2.
- LANES = SDRAM_W/ELEM_W (derived, not overridable).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid (driven by the reader's out_valid).
- in_idx  in  11  beat index within the burst (the reader's out_idx).
- in_data  in  SDRAM_W  beat data (the reader's out_data).
- rsv_req  in  1  request to reserve space for a burst.
- rsv_cnt  in  11  number of beats to reserve.
- rsv_grant  out  1  reservation accepted this cycle (combinational).
- rsv_err  out  1  registered one-cycle pulse: request can never be granted.
- elem_valid  out  1  element available.
- elem_ready  in  1  consumer accepts the element.
- elem_data  out  ELEM_W  current element.
- elem_lane  out  $clog2(LANES)  lane index of elem_data within its beat.
- level  out  $clog2(DEPTH)+1  beats stored.
- overflow  out  1  sticky flag: a beat was dropped.
- idx_err  out  1  sticky flag: a non-sequential in_idx was seen.
- stat_beats  out  32  beats accepted (see Configuration).
- stat_elems  out  32  elements popped (see Configuration).

## Operation
- **Storage.** The FIFO is a register array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH, plus an occupancy count of 0..DEPTH.
- **Write.**
  - When in_valid=1 and count<DEPTH, in_data is written at wr_ptr.
  - When in_valid=1 and count==DEPTH, the beat is dropped, overflow is set, and wr_ptr is unchanged.
  - There is no ready toward the reader; in_valid is never stalled.
- **Unpack.**
  - elem_valid = (count!=0).
  - elem_data = fifo[rd_ptr][lane*ELEM_W +: ELEM_W]. Lane 0 is the LSBs, so elements come out LSB-first.
  - elem_lane equals the lane counter.
  - On an elem_valid && elem_ready handshake, lane increments. At lane==LANES-1, lane wraps to 0, rd_ptr increments and the beat is popped.
- **Simultaneous write and pop** in the same cycle: count is unchanged and both pointers advance.
- **Reservation.**
  - free = DEPTH - count - reserved.
  - rsv_grant = rsv_req && rsv_cnt!=0 && rsv_cnt<=free.
  - On grant, reserved increases by rsv_cnt.
  - Each accepted beat decreases reserved by 1, saturating at 0.
  - A grant and a beat in the same cycle net out: reserved += rsv_cnt-1.
  - A request with rsv_cnt==0 or rsv_cnt>DEPTH pulses rsv_err the next cycle and is never granted.
  - A legal request that does not fit holds rsv_grant=0 until space frees; the requester keeps rsv_req asserted.
- **Index check.**
  - An expected-index register resets to 0.
  - On an accepted or dropped beat: if in_idx!=0 and in_idx!=expected, idx_err is set.
  - In either case, expected <= in_idx+1 (11-bit wrap).
  - in_idx==0 always restarts the sequence without flagging.
- **Flags.** overflow and idx_err clear only on rst.

## Timing
- Write latency: a beat presented in cycle N gives elem_valid=1 and level incremented in cycle N+1.
- Throughput: at most one element per cycle. Sustained beat input faster than one per LANES cycles fills the FIFO, which is why the reservation handshake must gate burst starts.
- rsv_grant is combinational in the same cycle as rsv_req; the reservation state updates at the next edge.
- Reset, including rst mid-burst or mid-beat, sets the following at the next edge:
  - pointers, count, lane, reserved and expected all to 0;
  - elem_valid=0, level=0, overflow=0, idx_err=0, rsv_err=0, stat counters=0.
  - Any partially unpacked beat is discarded. rsv_grant is 0 while rst=1.
- Outputs are undefined-free: elem_data reads storage, and storage resets to 0.

## Configuration
- Macro: SDRAM_UNPACK_STATS_EN.
- Defined: stat_beats counts beats written and stat_elems counts element handshakes. Both are 32-bit, wrap on overflow, and are cleared by rst.
- Not defined: no counter logic is built, and stat_beats and stat_elems are tied to 0. The port list is identical in both builds.

## Test plan
- Single beat 128'h0F0E…0100 with elem_ready=1: elem_data reads 8'h00, 8'h01 … 8'h0F on 16 consecutive cycles starting the cycle after in_valid; level returns to 0.
- rsv_req with rsv_cnt=16 on empty: grant same cycle. A second request with rsv_cnt=1 waits until the first element-beat pop; then 16 beats with in_idx 0..15 give overflow=0 and idx_err=0.
- Fill 16 beats with elem_ready=0, then a 17th beat: overflow=1, level=16, and the first element is still beat 0 lane 0.
- Beat write and final-lane pop in the same cycle at level=3: level stays 3, and the next element is lane 0 of the following beat.
- in_idx sequence 0,1,3: idx_err set on the third beat. rsv_cnt=0 gives rsv_err one-cycle pulse and grant=0. rst mid-unpack (lane=5) clears everything next cycle.
- With SDRAM_UNPACK_STATS_EN: after 4 beats fully drained, stat_beats=4 and stat_elems=64. Without the macro, both read 0.
